// File: rtl/irq_halt_ctrl.sv
// irq_halt_ctrl: I/O register front end (IE, IF ack, IME, POSTFLG, HALTCNT)
// and the RUN/HALT/STOP/WAKE sequencer that gates the CPU clock enable.
// Optional feature macro: STOP_MODE_EN -- when defined, HALTCNT bit 15 enters
// STOP (wakes only on serial/keypad/game pak); when undefined, every HALTCNT
// write enters HALT and stop_active is tied low.
// WAKE_DELAY must lie in 1..15 (it loads a 4-bit down-counter).
module irq_halt_ctrl #(
   parameter int unsigned WAKE_DELAY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] io_addr,
   input  logic        io_we,
   input  logic        io_re,
   input  logic [1:0]  io_be,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   input  logic [15:0] reg_IF,
   output logic [15:0] reg_IE,
   output logic        ime,
   output logic [15:0] reg_ACK,
   output logic        postflg,
   output logic        cpu_halt,
   output logic        stop_active
);

   // Halfword register offsets (byte offset >> 1)
   localparam logic [10:0] HW_IE   = 11'h100;  // 0x200
   localparam logic [10:0] HW_IF   = 11'h101;  // 0x202
   localparam logic [10:0] HW_IME  = 11'h104;  // 0x208
   localparam logic [10:0] HW_PWR  = 11'h180;  // 0x300 POSTFLG / 0x301 HALTCNT

   localparam logic [3:0]  WAKE_LOAD = 4'(WAKE_DELAY - 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STOP = 2'd2,
      WAKE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] ie_q, ie_d;
   logic        ime_q, ime_d;
   logic        pf_q, pf_d;
   logic [15:0] ack_q, ack_d;
   logic [15:0] rdata_q, rdata_d;

   logic [10:0] hw_addr;
   logic [15:0] be_mask;
   logic        halt_wr;
   logic        unused_addr_lsb;

   // Accesses are halfword-decoded; byte selection comes from io_be only.
   assign hw_addr         = io_addr[11:1];
   assign unused_addr_lsb = io_addr[0];
   assign be_mask         = {{8{io_be[1]}}, {8{io_be[0]}}};
   assign halt_wr         = io_we && (hw_addr == HW_PWR) && io_be[1];

   // Register file next-state: writes win over reads; ack pulses default low.
   always_comb begin
      ie_d    = ie_q;
      ime_d   = ime_q;
      pf_d    = pf_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      if (io_we) begin
         case (hw_addr)
            HW_IE:  ie_d  = (ie_q & ~be_mask) | (io_wdata & be_mask);
            HW_IF:  ack_d = io_wdata & be_mask;
            HW_IME: if (io_be[0]) ime_d = io_wdata[0];
            HW_PWR: if (io_be[0] && io_wdata[0]) pf_d = 1'b1;
            default: ;
         endcase
      end else if (io_re) begin
         case (hw_addr)
            HW_IE:   rdata_d = ie_q;
            HW_IF:   rdata_d = reg_IF;
            HW_IME:  rdata_d = {15'd0, ime_q};
            HW_PWR:  rdata_d = {15'd0, pf_q};
            default: rdata_d = '0;
         endcase
      end
   end

   // Register file state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ie_q    <= '0;
         ime_q   <= 1'b0;
         pf_q    <= 1'b0;
         ack_q   <= '0;
         rdata_q <= '0;
      end else begin
         ie_q    <= ie_d;
         ime_q   <= ime_d;
         pf_q    <= pf_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // Power sequencer next-state. HALT wakes on any enabled pending flag
   // (IME ignored); WAKE always runs to completion once entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (halt_wr) begin
`ifdef STOP_MODE_EN
               state_d = io_wdata[15] ? STOP : HALT;
`else
               state_d = HALT;
`endif
            end
         end
         HALT: begin
            if (|(ie_q & reg_IF)) begin
               state_d = WAKE;
               cnt_d   = WAKE_LOAD;
            end
         end
`ifdef STOP_MODE_EN
         STOP: begin
            // Only serial, keypad and game pak can wake from STOP.
            if (|(ie_q & reg_IF & 16'h3080)) begin
               state_d = WAKE;
               cnt_d   = WAKE_LOAD;
            end
         end
`endif
         WAKE: begin
            if (cnt_q == 4'd0) state_d = RUN;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Power sequencer state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io_rdata = rdata_q;
   assign reg_IE   = ie_q;
   assign ime      = ime_q;
   assign reg_ACK  = ack_q;
   assign postflg  = pf_q;
   assign cpu_halt = (state_q != RUN);
`ifdef STOP_MODE_EN
   assign stop_active = (state_q == STOP);
`else
   assign stop_active = 1'b0;
`endif

endmodule

// File: tb/tb_irq_halt_ctrl.sv
// Bench for irq_halt_ctrl: directed vector table, hand-written power-state
// sequences, then randomized traffic against a release-time reference model.
module tb_irq_halt_ctrl;
   localparam int WD = 2;
`ifdef STOP_MODE_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] io_addr;
   logic        io_we, io_re;
   logic [1:0]  io_be;
   logic [15:0] io_wdata, io_rdata, reg_IF, reg_IE, reg_ACK;
   logic        ime, postflg, cpu_halt, stop_active;

   always #5 clock = ~clock;

   irq_halt_ctrl #(.WAKE_DELAY(WD)) dut (
      .clock(clock), .reset(reset), .io_addr(io_addr), .io_we(io_we),
      .io_re(io_re), .io_be(io_be), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .reg_IF(reg_IF), .reg_IE(reg_IE), .ime(ime), .reg_ACK(reg_ACK),
      .postflg(postflg), .cpu_halt(cpu_halt), .stop_active(stop_active)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic we, input logic re, input logic [11:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
      io_we = we; io_re = re; io_addr = a; io_be = be; io_wdata = wd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 12'h000, 2'b00, 16'h0000);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic        we, re;
      logic [11:0] addr;
      logic [1:0]  be;
      logic [15:0] wd, rif;
      logic [15:0] e_ie;
      logic        e_ime;
      logic [15:0] e_ack, e_rd;
      logic        e_pf, e_halt;
   } vec_t;

   function automatic vec_t mk(logic we, logic re, logic [11:0] a, logic [1:0] be,
                               logic [15:0] wd, logic [15:0] rif, logic [15:0] ie,
                               logic im, logic [15:0] ack, logic [15:0] rd,
                               logic pf, logic h);
      vec_t v;
      v.we = we; v.re = re; v.addr = a; v.be = be; v.wd = wd; v.rif = rif;
      v.e_ie = ie; v.e_ime = im; v.e_ack = ack; v.e_rd = rd; v.e_pf = pf; v.e_halt = h;
      return v;
   endfunction

   // Reference model state
   logic [15:0] m_ie, m_ack, m_rd;
   logic        m_ime, m_pf, m_stalled, m_stopped;
   int          m_wake_edge, m_edge;

   task automatic model_reset();
      m_ie = '0; m_ack = '0; m_rd = '0; m_ime = 0; m_pf = 0;
      m_stalled = 0; m_stopped = 0; m_wake_edge = -1; m_edge = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      logic [11:0] a;
      logic [15:0] msk;
      logic        cond;
      a   = io_addr & 12'hFFE;
      msk = {{8{io_be[1]}}, {8{io_be[0]}}};
      // read path (pre-edge values)
      if (io_re && !io_we) begin
         if (a == 12'h200)      m_rd = m_ie;
         else if (a == 12'h202) m_rd = reg_IF;
         else if (a == 12'h208) m_rd = {15'd0, m_ime};
         else if (a == 12'h300) m_rd = {15'd0, m_pf};
         else                   m_rd = 16'h0000;
      end
      // power: stalled from the write until the release edge
      if (!m_stalled) begin
         if (io_we && a == 12'h300 && io_be[1]) begin
            m_stalled   = 1;
            m_stopped   = STOP_EN && io_wdata[15];
            m_wake_edge = -1;
         end
      end else if (m_wake_edge < 0) begin
         cond = m_stopped ? |(m_ie & reg_IF & 16'h3080) : |(m_ie & reg_IF);
         if (cond) begin
            m_wake_edge = m_edge + WD;
            m_stopped   = 0;
         end
      end else if (m_edge == m_wake_edge) begin
         m_stalled   = 0;
         m_wake_edge = -1;
      end
      // write path
      m_ack = 16'h0000;
      if (io_we) begin
         if (a == 12'h200) m_ie = (m_ie & ~msk) | (io_wdata & msk);
         if (a == 12'h202) m_ack = io_wdata & msk;
         if (a == 12'h208 && io_be[0]) m_ime = io_wdata[0];
         if (a == 12'h300 && io_be[0] && io_wdata[0]) m_pf = 1;
      end
      m_edge++;
   endtask

   initial begin
      vec_t tbl[$];
      int   cnt;
      logic [11:0] ra;

      reset = 1'b1;
      reg_IF = 16'h0000;
      idle();
      tick(); tick();
      check("rst_rdata", io_rdata, 16'h0000);
      check("rst_ie", reg_IE, 16'h0000);
      check("rst_ime", {15'd0, ime}, 16'h0000);
      check("rst_ack", reg_ACK, 16'h0000);
      check("rst_pf", {15'd0, postflg}, 16'h0000);
      check("rst_halt", {15'd0, cpu_halt}, 16'h0000);
      check("rst_stop", {15'd0, stop_active}, 16'h0000);
      reset = 1'b0;

      // ---------------- directed vector table ----------------
      //                we re addr     be     wd        rif       ie        ime ack       rd        pf halt
      tbl.push_back(mk(1, 0, 12'h200, 2'b11, 16'h3FFF, 16'h0000, 16'h3FFF, 0, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 0, 12'h208, 2'b11, 16'h0001, 16'h0000, 16'h3FFF, 1, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 1, 12'h200, 2'b00, 16'h0000, 16'h0000, 16'h3FFF, 1, 16'h0000, 16'h3FFF, 0, 0));
      tbl.push_back(mk(0, 1, 12'h208, 2'b00, 16'h0000, 16'h0000, 16'h3FFF, 1, 16'h0000, 16'h0001, 0, 0));
      tbl.push_back(mk(1, 0, 12'h202, 2'b11, 16'h0001, 16'h0009, 16'h3FFF, 1, 16'h0001, 16'h0001, 0, 0));
      tbl.push_back(mk(0, 0, 12'h000, 2'b00, 16'h0000, 16'h0009, 16'h3FFF, 1, 16'h0000, 16'h0001, 0, 0));
      tbl.push_back(mk(1, 0, 12'h202, 2'b10, 16'h0001, 16'h0009, 16'h3FFF, 1, 16'h0000, 16'h0001, 0, 0));
      tbl.push_back(mk(0, 1, 12'h202, 2'b00, 16'h0000, 16'h0009, 16'h3FFF, 1, 16'h0000, 16'h0009, 0, 0));
      tbl.push_back(mk(1, 1, 12'h200, 2'b01, 16'h00AA, 16'h0009, 16'h3FAA, 1, 16'h0000, 16'h0009, 0, 0));
      tbl.push_back(mk(0, 1, 12'h204, 2'b00, 16'h0000, 16'h0000, 16'h3FAA, 1, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 0, 12'h300, 2'b01, 16'h0000, 16'h0000, 16'h3FAA, 1, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 0, 12'h300, 2'b01, 16'h0001, 16'h0000, 16'h3FAA, 1, 16'h0000, 16'h0000, 1, 0));
      tbl.push_back(mk(0, 1, 12'h300, 2'b00, 16'h0000, 16'h0000, 16'h3FAA, 1, 16'h0000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h202, 2'b01, 16'hFFFF, 16'h0000, 16'h3FAA, 1, 16'h00FF, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h202, 2'b11, 16'h8000, 16'h0000, 16'h3FAA, 1, 16'h8000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h208, 2'b11, 16'h0000, 16'h0000, 16'h3FAA, 0, 16'h0000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h200, 2'b10, 16'h1200, 16'h0000, 16'h12AA, 0, 16'h0000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h200, 2'b11, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h300, 2'b01, 16'h0000, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0001, 1, 0));
      tbl.push_back(mk(1, 0, 12'h20C, 2'b11, 16'hFFFF, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0001, 1, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].be, tbl[i].wd);
         reg_IF = tbl[i].rif;
         tick();
         check($sformatf("vec%0d_ie", i), reg_IE, tbl[i].e_ie);
         check($sformatf("vec%0d_ime", i), {15'd0, ime}, {15'd0, tbl[i].e_ime});
         check($sformatf("vec%0d_ack", i), reg_ACK, tbl[i].e_ack);
         check($sformatf("vec%0d_rdata", i), io_rdata, tbl[i].e_rd);
         check($sformatf("vec%0d_pf", i), {15'd0, postflg}, {15'd0, tbl[i].e_pf});
         check($sformatf("vec%0d_halt", i), {15'd0, cpu_halt}, {15'd0, tbl[i].e_halt});
      end
      idle();
      reg_IF = 16'h0000;

      // ---------------- HALT then wake on IF[0] ----------------
      drive(1, 0, 12'h300, 2'b10, 16'h0000);
      tick();
      check("halt_entry", {15'd0, cpu_halt}, 16'h0001);
      check("halt_no_stop", {15'd0, stop_active}, 16'h0000);
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt_hold", {15'd0, cpu_halt}, 16'h0001);
      end
      drive(1, 0, 12'h200, 2'b10, 16'h0100);   // DMA-style write while halted
      tick();
      check("ie_write_in_halt", reg_IE, 16'h0101);
      drive(1, 0, 12'h300, 2'b10, 16'h8000);   // ignored outside RUN
      tick();
      check("haltcnt_ignored", {15'd0, stop_active}, 16'h0000);
      check("haltcnt_ignored_h", {15'd0, cpu_halt}, 16'h0001);
      idle();
      reg_IF = 16'h0001;                       // cycle N
      tick();
      check("wake_n1", {15'd0, cpu_halt}, 16'h0001);
      reg_IF = 16'h0000;                       // dropping it must not abort the wake
      tick();
      check("wake_n2", {15'd0, cpu_halt}, 16'h0001);
      tick();
      check("wake_n3_run", {15'd0, cpu_halt}, 16'h0000);

      // ---------------- HALT with interrupt already pending ----------------
      drive(1, 0, 12'h200, 2'b11, 16'h0004);
      tick();
      reg_IF = 16'h0004;
      drive(1, 0, 12'h300, 2'b10, 16'h0000);
      tick();
      idle();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (cpu_halt) cnt++;
         tick();
      end
      check("pending_halt_len", 16'(cnt), 16'(1 + WD));
      reg_IF = 16'h0000;

      // ---------------- STOP (or HALT when STOP is not built) ----------------
      drive(1, 0, 12'h200, 2'b11, 16'h1001);
      tick();
      drive(1, 0, 12'h300, 2'b10, 16'h8000);
      tick();
      idle();
`ifdef STOP_MODE_EN
      check("stop_entry", {15'd0, stop_active}, 16'h0001);
      check("stop_entry_h", {15'd0, cpu_halt}, 16'h0001);
      reg_IF = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stop_no_wake", {15'd0, stop_active}, 16'h0001);
      end
      reg_IF = 16'h1001;
      tick();
      check("stop_wake_sa", {15'd0, stop_active}, 16'h0000);
      check("stop_wake_h1", {15'd0, cpu_halt}, 16'h0001);
      tick();
      check("stop_wake_h2", {15'd0, cpu_halt}, 16'h0001);
      tick();
      check("stop_wake_run", {15'd0, cpu_halt}, 16'h0000);
`else
      check("stop_as_halt", {15'd0, cpu_halt}, 16'h0001);
      check("stop_tied_low", {15'd0, stop_active}, 16'h0000);
      reg_IF = 16'h0001;
      tick();
      check("stop_as_halt_h1", {15'd0, cpu_halt}, 16'h0001);
      tick();
      check("stop_as_halt_h2", {15'd0, cpu_halt}, 16'h0001);
      tick();
      check("stop_as_halt_run", {15'd0, cpu_halt}, 16'h0000);
`endif
      reg_IF = 16'h0000;

      // ---------------- asynchronous reset during HALT ----------------
      drive(1, 0, 12'h208, 2'b01, 16'h0001);
      tick();
      drive(1, 0, 12'h300, 2'b10, 16'h0000);
      tick();
      idle();
      check("pre_rst_halt", {15'd0, cpu_halt}, 16'h0001);
      #2 reset = 1'b1;
      #1;
      check("async_rst_halt", {15'd0, cpu_halt}, 16'h0000);
      check("async_rst_ie", reg_IE, 16'h0000);
      check("async_rst_ime", {15'd0, ime}, 16'h0000);
      #2 reset = 1'b0;
      drive(1, 0, 12'h300, 2'b10, 16'h0000);
      tick();
      check("reenter_halt", {15'd0, cpu_halt}, 16'h0001);
      idle();

      // ---------------- randomized traffic vs. reference model ----------------
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 7))
            0, 7:    ra = 12'h200;
            1:       ra = 12'h202;
            2:       ra = 12'h208;
            3:       ra = 12'h300;
            4:       ra = 12'h301;
            5:       ra = 12'h204;
            default: ra = 12'($urandom_range(0, 4095));
         endcase
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra,
               2'($urandom_range(0, 3)), 16'($urandom));
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0:       reg_IF = 16'h0000;
               1:       reg_IF = 16'($urandom);
               default: reg_IF = 16'(1) << $urandom_range(0, 15);
            endcase
         end
         model_step();
         tick();
         check("rnd_ie", reg_IE, m_ie);
         check("rnd_ime", {15'd0, ime}, {15'd0, m_ime});
         check("rnd_ack", reg_ACK, m_ack);
         check("rnd_rdata", io_rdata, m_rd);
         check("rnd_pf", {15'd0, postflg}, {15'd0, m_pf});
         check("rnd_halt", {15'd0, cpu_halt}, {15'd0, m_stalled});
         check("rnd_stop", {15'd0, stop_active}, {15'd0, m_stopped & m_stalled});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/irq_halt_ctrl.md
# irq_halt_ctrl

Register front end and power-state sequencer for the interrupt controller. Decodes CPU/DMA I/O writes to IE, IF, IME, POSTFLG and HALTCNT, and drives the controller's `reg_IE`, `ime` and one-cycle `reg_ACK` clear pulses. Runs the HALT/STOP state machine that gates the CPU clock enable until an enabled interrupt is pending. Sits between the I/O register bus and `interrupt_controller` in the CPU subsystem.

## Interface
- WAKE_DELAY, 2: cycles in WAKE before `cpu_halt` drops; legal range 1–15.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- io_addr  in  12  byte offset within I/O space (0x000–0xFFF)
- io_we  in  1  write strobe, one cycle per access
- io_re  in  1  read strobe
- io_be  in  2  byte enables, [0]=low byte, [1]=high byte
- io_wdata  in  16  write data
- io_rdata  out  16  registered read data
- reg_IF  in  16  pending flags from interrupt controller
- reg_IE  out  16  interrupt enable register
- ime  out  1  IME bit 0
- reg_ACK  out  16  one-cycle clear pulses to interrupt controller
- postflg  out  1  POSTFLG bit 0
- cpu_halt  out  1  CPU clock-enable gate; high means CPU stalled
- stop_active  out  1  high in STOP state only

## Operation
- Halfword offsets:
  - 0x200 IE: R/W, per-byte via `io_be`.
  - 0x202 IF: reads `reg_IF`. A write sets `reg_ACK[i]` for each written 1, masked by `io_be`; writing 0 has no effect.
  - 0x208 IME: bit 0 R/W; other bits read 0.
  - 0x300 low byte POSTFLG: bit 0, set-only; a write of 0 is ignored.
  - 0x300 high byte HALTCNT (0x301): write-only; reads 0.
- Unmapped offsets: writes ignored, reads return 0.
- One access per cycle. If `io_we` and `io_re` are both high, the write wins and `io_rdata` holds its previous value.
- States: RUN, HALT, STOP, WAKE.
  - RUN → HALT: write to 0x301 with `io_be[1]` set and `io_wdata[15]`=0.
  - RUN → STOP: write to 0x301 with `io_be[1]` set and `io_wdata[15]`=1.
  - Writes to 0x301 outside RUN are ignored.
  - HALT → WAKE: when `|(reg_IE & reg_IF)`. IME is not consulted.
  - STOP → WAKE: when `|(reg_IE & reg_IF & 16'h3080)`, i.e. serial, keypad or game pak only.
  - WAKE: 4-bit counter loads WAKE_DELAY-1 and decrements; → RUN when it reaches 0.
- `cpu_halt` = state ≠ RUN. `stop_active` = state == STOP.
- I/O writes (e.g. DMA) are accepted in every state.

## Timing
- Reset values:
  - `reg_IE`=0, `ime`=0, `postflg`=0, `reg_ACK`=0.
  - `io_rdata`=0, `cpu_halt`=0, `stop_active`=0.
  - State = RUN, WAKE counter = 0.
- Register writes take effect the cycle after `io_we` is sampled.
- `reg_ACK` is registered: high exactly one cycle, the cycle after the IF write, then 0. Back-to-back IF writes produce back-to-back pulses.
- `io_rdata` is valid the cycle after `io_re` and holds until the next read.
- HALT/STOP entry: `cpu_halt` goes high the cycle after the 0x301 write.
- If an enabled interrupt is already pending at HALT entry, the sequence is HALT for 1 cycle, then WAKE, then RUN. No lock-up.
- Wake condition sampled in cycle N → WAKE at N+1 → `cpu_halt` low at N+1+WAKE_DELAY.
- Pending condition deasserting during WAKE does not abort the wake.
- Reset mid-HALT/STOP/WAKE returns to RUN immediately (asynchronous) and drops `cpu_halt`.

## Configuration
- `STOP_MODE_EN` defined: STOP state implemented as above.
- Undefined:
  - A HALTCNT write with bit 15=1 enters HALT; STOP is unreachable.
  - `stop_active` is tied to 0.
  - The STOP wake mask is not synthesized.

## Test plan
- IE/IME: write 16'h3FFF to 0x200 with be=11, then 1 to 0x208 → `reg_IE`=16'h3FFF and `ime`=1 one cycle later. Readback of each returns the same values.
- IF ack: `reg_IF`=16'h0009; write 16'h0001 to 0x202 → `reg_ACK`=16'h0001 for exactly one cycle. Repeat with be=10 → `reg_ACK` stays 0.
- HALT wake: `reg_IE`=1, `reg_IF`=0, write 16'h0000 to 0x300 with be=10 → `cpu_halt`=1. Raise `reg_IF`[0] at cycle N → `cpu_halt`=0 at N+3 (WAKE_DELAY=2).
- HALT with pending interrupt: `reg_IE`=`reg_IF`=16'h0004 when the HALT write occurs → `cpu_halt` high for exactly 1+WAKE_DELAY cycles.
- STOP (`STOP_MODE_EN`): `reg_IE`=16'h1001, write 16'h8000 to 0x300 with be=10.
  - `reg_IF`[0] rising → no wake.
  - `reg_IF`[12] rising → `stop_active` drops next cycle; `cpu_halt` drops WAKE_DELAY cycles later.
- Reset during HALT → `cpu_halt`=0, `reg_IE`=0, `ime`=0 immediately. A following HALTCNT write re-enters HALT.
